ula_sequencer: RTL
==================

ULA_SEQUENCER -- requirements
Module: ula_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the clock port SHALL be named clk and the reset port rst.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4: request queue entries; power of two, at least 2.
REQ-003 The block SHALL have parameter ULA_LAT, default 2: clock edges from driving ula_* to ula_c valid.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit: request present.
REQ-007 The block SHALL have port req_ready, output, 1 bit: queue can accept a request.
REQ-008 The block SHALL have port req_op, input, 3 bits: ALU opcode (000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 not A, 111 pass B).
REQ-009 The block SHALL have port req_shift, input, 1 bit: 1 = shift the result left.
REQ-010 The block SHALL have ports req_a and req_b, input, 8 bits each: operands.
REQ-011 The block SHALL have ports ula_crtl_ula (output, 3 bits), ula_crtl_des (output, 1 bit), ula_a (output, 8 bits) and ula_b (output, 8 bits): drive the downstream ALU.
REQ-012 The block SHALL have port ula_c, input, 8 bits: ALU result.
REQ-013 The block SHALL have port res_valid, output, 1 bit: result available.
REQ-014 The block SHALL have port res_ready, input, 1 bit: consumer accepts the result.
REQ-015 The block SHALL have port res_data, output, 8 bits: captured result.
REQ-016 The block SHALL have port res_err, output, 1 bit: divide-by-zero flag.
REQ-017 The block SHALL have port busy, output, 1 bit: high when the FSM is not IDLE or the queue is not empty.

Function
REQ-018 Requests SHALL be queued in an in-order FIFO of FIFO_DEPTH entries; each entry holds op, shift, a and b.
REQ-019 req_ready SHALL equal !full, combinational from registered state; a push SHALL occur on any edge where req_valid && req_ready.
REQ-020 A push and a pop in the same cycle SHALL both take effect, and the count SHALL be unchanged.
REQ-021 When the FIFO is full, req_ready SHALL be 0 even if a pop occurs in that cycle.
REQ-022 The FSM SHALL have states IDLE, WAIT and DONE.
REQ-023 From IDLE with the queue not empty, the FSM SHALL on the next edge pop the head, register it onto ula_*, clear the wait counter and enter WAIT.
REQ-024 ula_* outputs SHALL hold stable from issue until the next issue.
REQ-025 In WAIT the counter SHALL increment each edge; on the edge where the counter equals ULA_LAT-1, the FSM SHALL capture ula_c into res_data and enter DONE.
REQ-026 res_valid SHALL be 1 exactly while the FSM is in DONE.
REQ-027 res_data and res_err SHALL stay stable while res_valid && !res_ready.
REQ-028 In DONE, on res_valid && res_ready: with the queue not empty, the FSM SHALL issue the next entry directly and enter WAIT; otherwise it SHALL enter IDLE.
REQ-029 Latency SHALL be: a request pushed at edge N into an empty, idle block is issued at edge N+1 and has res_valid high after edge N+1+ULA_LAT.
REQ-030 Results SHALL leave in request order, with none dropped or duplicated.

Reset
REQ-031 While rst is high at an edge, the FSM SHALL go to IDLE, the FIFO SHALL be emptied, and the counter SHALL be cleared.
REQ-032 While rst is high at an edge, ula_crtl_ula, ula_crtl_des, ula_a, ula_b, res_data, res_valid and res_err SHALL be set to 0.
REQ-033 req_ready SHALL be 0 while rst is asserted.
REQ-034 A reset in WAIT or DONE SHALL discard the in-flight and queued requests, and no result for them SHALL ever appear.

Configuration
REQ-035 With macro ULA_SEQ_DIVZERO_EN defined, a head entry with op 011 and b == 0 SHALL not be sent to the ALU: ula_* is left unchanged, the FSM enters DONE on the next edge, res_data = 8'hFF and res_err = 1.
REQ-036 With ULA_SEQ_DIVZERO_EN defined, all other entries SHALL produce res_err = 0.
REQ-037 Without ULA_SEQ_DIVZERO_EN, divide-by-zero entries SHALL be issued normally, and res_err SHALL be constant 0.

Verification
REQ-038 The bench SHALL cover: push op=000, a=10, b=2, shift=0, res_ready=1 -> ula_crtl_ula=000 after edge N+1; res_valid high after edge N+3 with res_data=12.
REQ-039 The bench SHALL cover: push op=000, a=10, b=2, shift=1 -> res_data=24, with ula_crtl_des=1 during WAIT.
REQ-040 The bench SHALL cover: res_ready=0 while pushing 6 requests (sub 3-7, mul 2*2, div 20/10, and 0&255, or 255|0, pass B=40) -> 5 accepted (1 in flight plus 4 queued), req_ready=0 and res_data=252 held stable; then res_ready=1 -> outputs 252, 4, 2, 0, 255, 40 in order.
REQ-041 The bench SHALL cover: ULA_SEQ_DIVZERO_EN defined, push op=011, a=20, b=0 -> res_valid after edge N+2, res_data=8'hFF, res_err=1, ula_* unchanged; without the macro -> ALU result after N+3, res_err=0.
REQ-042 The bench SHALL cover: rst pulse for one edge while in WAIT with 2 queued -> res_valid=0, busy=0 and ula_* = 0 after that edge, with no later results.
REQ-043 The bench SHALL cover: continuous push with res_ready=1 -> one result every ULA_LAT+1 cycles, with no gaps beyond that.

Source files
------------

// File: rtl/ula_sequencer.sv
// ula_sequencer: queues ALU requests, drives a fixed-latency external ALU, returns results in request order.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            request handshake; req_op, req_shift, req_a, req_b carry the request
//   ula_crtl_ula, ula_crtl_des,
//   ula_a, ula_b / ula_c           downstream ALU drive, and its result ULA_LAT edges later
//   res_valid/res_ready            result handshake; res_data result, res_err divide-by-zero flag
//   busy                           FSM not idle or queue not empty
// Macro ULA_SEQ_DIVZERO_EN: answer divide-by-zero entries locally with 8'hFF and res_err=1.
module ula_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ULA_LAT    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic       req_shift,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    output logic [2:0] ula_crtl_ula,
    output logic       ula_crtl_des,
    output logic [7:0] ula_a,
    output logic [7:0] ula_b,
    input  logic [7:0] ula_c,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_err,
    output logic       busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (ULA_LAT > 1) ? $clog2(ULA_LAT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [19:0]   mem_q [FIFO_DEPTH];
    logic [19:0]   head;
    logic [2:0]    ula_op_q, ula_op_d;
    logic          ula_des_q, ula_des_d;
    logic [7:0]    ula_a_q, ula_a_d, ula_b_q, ula_b_d, res_data_q, res_data_d;
    logic          res_valid_q, res_valid_d, res_err_q, res_err_d, divz_q, divz_d;
    logic          empty, full, push, issue, head_dz;

    // entry layout: {op[19:17], shift[16], a[15:8], b[7:0]}
    assign head  = mem_q[rd_ptr_q];
    assign empty = count_q == '0;
    assign full  = count_q == (AW+1)'(FIFO_DEPTH);
    assign push  = req_valid && req_ready;
    // a new entry leaves the queue from IDLE, or straight out of DONE as the result is taken
    assign issue = !empty && (state_q == IDLE || (state_q == DONE && res_ready));

`ifdef ULA_SEQ_DIVZERO_EN
    assign head_dz = head[19:17] == 3'b011 && head[7:0] == 8'd0;
`else
    assign head_dz = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ula_op_d    = ula_op_q;
        ula_des_d   = ula_des_q;
        ula_a_d     = ula_a_q;
        ula_b_d     = ula_b_q;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;
        divz_d      = divz_q;
        wr_ptr_d    = wr_ptr_q + AW'(push);
        rd_ptr_d    = rd_ptr_q + AW'(issue);
        count_d     = count_q + (AW+1)'(push) - (AW+1)'(issue);
        if (state_q == WAIT) begin
            cnt_d = cnt_q + 1'b1;
            // a locally answered divide-by-zero skips the ALU wait entirely
            if (divz_q || cnt_q == CW'(ULA_LAT - 1)) begin
                state_d    = DONE;
                res_data_d = divz_q ? 8'hFF : ula_c;
                res_err_d  = divz_q;
            end
        end
        if (state_q == DONE && res_ready)
            state_d = IDLE;
        if (issue) begin
            state_d = WAIT;
            cnt_d   = '0;
            divz_d  = head_dz;
            // a divide-by-zero entry leaves the ALU drive untouched
            if (!head_dz) begin
                ula_op_d  = head[19:17];
                ula_des_d = head[16];
                ula_a_d   = head[15:8];
                ula_b_d   = head[7:0];
            end
        end
        res_valid_d = state_d == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ula_op_q    <= '0;
            ula_des_q   <= 1'b0;
            ula_a_q     <= '0;
            ula_b_q     <= '0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
            divz_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ula_op_q    <= ula_op_d;
            ula_des_q   <= ula_des_d;
            ula_a_q     <= ula_a_d;
            ula_b_q     <= ula_b_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
            res_valid_q <= res_valid_d;
            divz_q      <= divz_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= {req_op, req_shift, req_a, req_b};
    end

    assign req_ready    = !full && !rst;
    assign ula_crtl_ula = ula_op_q;
    assign ula_crtl_des = ula_des_q;
    assign ula_a        = ula_a_q;
    assign ula_b        = ula_b_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_err      = res_err_q;
    assign busy         = state_q != IDLE || !empty;
endmodule
